// File: rtl/hbridge_phase_monitor_pkg.sv
// Shared types for the H-bridge phase monitor: coil polarity codes,
// electrical quadrant constants, quadrant-delta codes and decode helpers.
// Coil pattern bit order is {X2, X1}; X1 is the high-side drive.
package hbridge_mon_pkg;

  // Coil drive pattern {X2,X1}: X1 alone drives positive, X2 alone negative.
  typedef enum logic [1:0] {
    POL_OFF   = 2'b00,
    POL_POS   = 2'b01,
    POL_NEG   = 2'b10,
    POL_FAULT = 2'b11
  } pol_e;

  // Electrical quadrants: (A+,B+)=Q0, (A-,B+)=Q1, (A-,B-)=Q2, (A+,B-)=Q3.
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // Quadrant delta, new minus old modulo 4.
  typedef enum logic [1:0] {
    STAY = 2'd0,
    FWD  = 2'd1,
    SKIP = 2'd2,
    REV  = 2'd3
  } qdelta_e;

  // Default motor count.
  localparam int MOTOR_COUNT_DEF = 1;

  // True when the coil is actively driven in either direction.
  function automatic logic pol_driven(input pol_e p);
    return (p == POL_POS) || (p == POL_NEG);
  endfunction

  // Quadrant from the negative-polarity flags of coils A and B.
  function automatic logic [1:0] quad_of(input logic a_neg, input logic b_neg);
    logic [1:0] q;
    case ({a_neg, b_neg})
      2'b00:   q = Q0;
      2'b10:   q = Q1;
      2'b11:   q = Q2;
      default: q = Q3;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/hbridge_phase_monitor_if.sv
// Bundle of the monitored DUAL_HBRIDGE phases, the clear strobe and the
// monitor results. master = stimulus/bench side, slave = the monitor.
interface hbridge_phase_monitor_if #(
  parameter int MOTOR_COUNT = 1,
  parameter int WINDOW_BITS = 8,
  parameter int STEP_BITS   = 32
);
  logic [MOTOR_COUNT-1:0]             PHASE_A1;
  logic [MOTOR_COUNT-1:0]             PHASE_A2;
  logic [MOTOR_COUNT-1:0]             PHASE_B1;
  logic [MOTOR_COUNT-1:0]             PHASE_B2;
  logic                               clear;
  logic [MOTOR_COUNT*WINDOW_BITS-1:0] duty_a;
  logic [MOTOR_COUNT*WINDOW_BITS-1:0] duty_b;
  logic                               duty_valid;
  logic [MOTOR_COUNT*STEP_BITS-1:0]   position;
  logic [MOTOR_COUNT-1:0]             fault_shoot;
  logic [MOTOR_COUNT-1:0]             fault_skip;

  modport master (
    output PHASE_A1, PHASE_A2, PHASE_B1, PHASE_B2, clear,
    input  duty_a, duty_b, duty_valid, position, fault_shoot, fault_skip
  );

  modport slave (
    input  PHASE_A1, PHASE_A2, PHASE_B1, PHASE_B2, clear,
    output duty_a, duty_b, duty_valid, position, fault_shoot, fault_skip
  );
endinterface

// File: rtl/hbridge_phase_monitor_channel.sv
// One motor: 2-flop sync, coil decode, optional deglitch (HBRIDGE_MON_DEGLITCH_EN),
// quadrant tracking, signed full-step position, sticky faults, duty accumulators.
// Position/faults update 3 cycles after a phase edge (6 with deglitch).
module hbridge_mon_channel
  import hbridge_mon_pkg::*;
#(
  parameter int WINDOW_BITS = 8,
  parameter int STEP_BITS   = 32
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   i_a1,
  input  logic                   i_a2,
  input  logic                   i_b1,
  input  logic                   i_b2,
  input  logic                   i_clear,
  input  logic                   i_win_end,
  output logic [WINDOW_BITS-1:0] o_duty_a,
  output logic [WINDOW_BITS-1:0] o_duty_b,
  output logic [STEP_BITS-1:0]   o_position,
  output logic                   o_fault_shoot,
  output logic                   o_fault_skip
);

  localparam logic [STEP_BITS-1:0] STEP_ONE = {{(STEP_BITS-1){1'b0}}, 1'b1};

  logic [1:0] r_a_s1, r_a_s2, r_b_s1, r_b_s2;
  logic       r_neg_a, r_neg_b, r_known_a, r_known_b, r_qref;
  logic [1:0] r_quad;
  logic [STEP_BITS-1:0]   r_pos;
  logic                   r_shoot, r_skip;
  logic [WINDOW_BITS-1:0] r_acc_a, r_acc_b, r_duty_a, r_duty_b;

  pol_e       w_pol_a, w_pol_b;
  logic       w_drv_a, w_drv_b, w_acc_a, w_acc_b;
  logic       w_neg_a_nx, w_neg_b_nx, w_known_a_nx, w_known_b_nx, w_both, w_step_en;
  logic [1:0] w_quad_nx, w_qdiff;
  qdelta_e    w_delta;
  logic [WINDOW_BITS-1:0] w_inc_a, w_inc_b;

  // Two-flop synchroniser on every phase bit, kept as {X2,X1} coil patterns.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_a_s1 <= 2'b00;
      r_a_s2 <= 2'b00;
      r_b_s1 <= 2'b00;
      r_b_s2 <= 2'b00;
    end else begin
      r_a_s1 <= {i_a2, i_a1};
      r_a_s2 <= r_a_s1;
      r_b_s1 <= {i_b2, i_b1};
      r_b_s2 <= r_b_s1;
    end
  end

  assign w_pol_a = pol_e'(r_a_s2);
  assign w_pol_b = pol_e'(r_b_s2);
  assign w_drv_a = pol_driven(w_pol_a);
  assign w_drv_b = pol_driven(w_pol_b);

`ifdef HBRIDGE_MON_DEGLITCH_EN
  logic [1:0] r_cand_a, r_cnt_a, r_cand_b, r_cnt_b;

  // Track how long the synchronised pattern has been unchanged (saturating).
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_cand_a <= 2'b00;
      r_cnt_a  <= 2'd0;
      r_cand_b <= 2'b00;
      r_cnt_b  <= 2'd0;
    end else begin
      if (r_a_s2 == r_cand_a) begin
        if (r_cnt_a != 2'd3) r_cnt_a <= r_cnt_a + 2'd1;
      end else begin
        r_cand_a <= r_a_s2;
        r_cnt_a  <= 2'd0;
      end
      if (r_b_s2 == r_cand_b) begin
        if (r_cnt_b != 2'd3) r_cnt_b <= r_cnt_b + 2'd1;
      end else begin
        r_cand_b <= r_b_s2;
        r_cnt_b  <= 2'd0;
      end
    end
  end

  // Accept a polarity only on its 4th consecutive identical sample.
  assign w_acc_a = w_drv_a && (r_a_s2 == r_cand_a) && (r_cnt_a >= 2'd2);
  assign w_acc_b = w_drv_b && (r_b_s2 == r_cand_b) && (r_cnt_b >= 2'd2);
`else
  assign w_acc_a = w_drv_a;
  assign w_acc_b = w_drv_b;
`endif

  // OFF and FAULT leave the last polarity untouched.
  assign w_neg_a_nx   = w_acc_a ? (w_pol_a == POL_NEG) : r_neg_a;
  assign w_neg_b_nx   = w_acc_b ? (w_pol_b == POL_NEG) : r_neg_b;
  assign w_known_a_nx = r_known_a | w_acc_a;
  assign w_known_b_nx = r_known_b | w_acc_b;
  assign w_both       = w_known_a_nx & w_known_b_nx;
  assign w_quad_nx    = quad_of(w_neg_a_nx, w_neg_b_nx);
  assign w_qdiff      = w_quad_nx - r_quad;
  assign w_delta      = qdelta_e'(w_qdiff);
  // The first valid quadrant only sets the reference.
  assign w_step_en    = w_both & r_qref;

  // Last polarity, known flags and quadrant reference; clear leaves these alone.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_neg_a   <= 1'b0;
      r_neg_b   <= 1'b0;
      r_known_a <= 1'b0;
      r_known_b <= 1'b0;
      r_quad    <= Q0;
      r_qref    <= 1'b0;
    end else begin
      r_neg_a   <= w_neg_a_nx;
      r_neg_b   <= w_neg_b_nx;
      r_known_a <= w_known_a_nx;
      r_known_b <= w_known_b_nx;
      if (w_both) begin
        r_quad <= w_quad_nx;
        r_qref <= 1'b1;
      end
    end
  end

  // Position and sticky faults; clear overrides any step or fault that cycle.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_pos   <= '0;
      r_shoot <= 1'b0;
      r_skip  <= 1'b0;
    end else if (i_clear) begin
      r_pos   <= '0;
      r_shoot <= 1'b0;
      r_skip  <= 1'b0;
    end else begin
      if (w_step_en) begin
        case (w_delta)
          FWD:     r_pos  <= r_pos + STEP_ONE;
          REV:     r_pos  <= r_pos - STEP_ONE;
          SKIP:    r_skip <= 1'b1;
          default: ;
        endcase
      end
      if ((w_pol_a == POL_FAULT) || (w_pol_b == POL_FAULT)) r_shoot <= 1'b1;
    end
  end

  assign w_inc_a = {{(WINDOW_BITS-1){1'b0}}, w_drv_a};
  assign w_inc_b = {{(WINDOW_BITS-1){1'b0}}, w_drv_b};

  // Driven-cycle accumulators; the window end publishes the count including this cycle.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_acc_a  <= '0;
      r_acc_b  <= '0;
      r_duty_a <= '0;
      r_duty_b <= '0;
    end else if (i_clear) begin
      r_acc_a <= '0;
      r_acc_b <= '0;
    end else if (i_win_end) begin
      r_duty_a <= r_acc_a + w_inc_a;
      r_duty_b <= r_acc_b + w_inc_b;
      r_acc_a  <= '0;
      r_acc_b  <= '0;
    end else begin
      r_acc_a <= r_acc_a + w_inc_a;
      r_acc_b <= r_acc_b + w_inc_b;
    end
  end

  assign o_duty_a      = r_duty_a;
  assign o_duty_b      = r_duty_b;
  assign o_position    = r_pos;
  assign o_fault_shoot = r_shoot;
  assign o_fault_skip  = r_skip;

endmodule

// File: rtl/hbridge_phase_monitor.sv
// Top: MOTOR_COUNT independent channels plus the shared duty window counter.
// Position latency 3 cycles (6 with HBRIDGE_MON_DEGLITCH_EN); duty window 2^WINDOW_BITS-1 cycles.
// Pure observer: no backpressure, samples the phases every cycle.
module hbridge_phase_monitor
  import hbridge_mon_pkg::*;
#(
  parameter int MOTOR_COUNT = MOTOR_COUNT_DEF,
  parameter int WINDOW_BITS = 8,
  parameter int STEP_BITS   = 32
) (
  input logic                     CLK,
  input logic                     reset,
  hbridge_phase_monitor_if.slave  mon
);

  localparam logic [WINDOW_BITS-1:0] WIN_LAST = WINDOW_BITS'((2 ** WINDOW_BITS) - 2);

  logic [WINDOW_BITS-1:0] r_win;
  logic                   r_dv;
  logic                   w_win_end;

  logic [MOTOR_COUNT*WINDOW_BITS-1:0] w_duty_a, w_duty_b;
  logic [MOTOR_COUNT*STEP_BITS-1:0]   w_position;
  logic [MOTOR_COUNT-1:0]             w_shoot, w_skip;

  assign w_win_end = (r_win == WIN_LAST);

  // Shared window counter; duty_valid follows the window end by one cycle.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_win <= '0;
      r_dv  <= 1'b0;
    end else if (mon.clear) begin
      r_win <= '0;
      r_dv  <= 1'b0;
    end else if (w_win_end) begin
      r_win <= '0;
      r_dv  <= 1'b1;
    end else begin
      r_win <= r_win + {{(WINDOW_BITS-1){1'b0}}, 1'b1};
      r_dv  <= 1'b0;
    end
  end

  for (genvar g = 0; g < MOTOR_COUNT; g++) begin : g_motor
    hbridge_mon_channel #(
      .WINDOW_BITS (WINDOW_BITS),
      .STEP_BITS   (STEP_BITS)
    ) u_channel (
      .CLK           (CLK),
      .reset         (reset),
      .i_a1          (mon.PHASE_A1[g]),
      .i_a2          (mon.PHASE_A2[g]),
      .i_b1          (mon.PHASE_B1[g]),
      .i_b2          (mon.PHASE_B2[g]),
      .i_clear       (mon.clear),
      .i_win_end     (w_win_end),
      .o_duty_a      (w_duty_a[g*WINDOW_BITS +: WINDOW_BITS]),
      .o_duty_b      (w_duty_b[g*WINDOW_BITS +: WINDOW_BITS]),
      .o_position    (w_position[g*STEP_BITS +: STEP_BITS]),
      .o_fault_shoot (w_shoot[g]),
      .o_fault_skip  (w_skip[g])
    );
  end

  assign mon.duty_a      = w_duty_a;
  assign mon.duty_b      = w_duty_b;
  assign mon.duty_valid  = r_dv;
  assign mon.position    = w_position;
  assign mon.fault_shoot = w_shoot;
  assign mon.fault_skip  = w_skip;

endmodule

// File: tb/tb_hbridge_phase_monitor.sv
// Bench for hbridge_phase_monitor: directed scenarios plus a random walk,
// compared every cycle against a sample-history reference model.
module tb_hbridge_phase_monitor;

  localparam int MC      = 2;
  localparam int WB      = 4;
  localparam int SB      = 32;
  localparam int WIN_LEN = (1 << WB) - 1;
`ifdef HBRIDGE_MON_DEGLITCH_EN
  localparam bit DG  = 1'b1;
  localparam int LAT = 6;
`else
  localparam bit DG  = 1'b0;
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hbridge_phase_monitor_if #(.MOTOR_COUNT(MC), .WINDOW_BITS(WB), .STEP_BITS(SB)) mon_if ();

  hbridge_phase_monitor #(.MOTOR_COUNT(MC), .WINDOW_BITS(WB), .STEP_BITS(SB)) dut (
    .CLK   (clk),
    .reset (rst),
    .mon   (mon_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input longint got, input longint want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // h*[m][j] = coil pattern {X2,X1} sampled j edges ago; the monitor acts on j=2.
  logic [1:0]          ha [MC][6];
  logic [1:0]          hb [MC][6];
  bit                  k_a [MC], k_b [MC], n_a [MC], n_b [MC], qv [MC];
  int                  mq [MC];
  logic signed [SB-1:0] mpos [MC];
  bit                  mshoot [MC], mskip [MC];
  int                  acc_a [MC], acc_b [MC], mduty_a [MC], mduty_b [MC];
  int                  nsamp;
  bit                  mdv;
  int                  qtab [2][2] = '{'{0, 3}, '{1, 2}};  // [a_neg][b_neg]

  function automatic bit is_drv(input logic [1:0] p);
    return (p == 2'b01) || (p == 2'b10);
  endfunction

  // A polarity counts once it is driven and (with deglitch) held 4 samples.
  function automatic bit accepted(input logic [1:0] h0, h1, h2, h3);
    return is_drv(h0) && (!DG || (h0 == h1 && h1 == h2 && h2 == h3));
  endfunction

  task automatic model_reset();
    for (int m = 0; m < MC; m++) begin
      for (int j = 0; j < 6; j++) begin ha[m][j] = 2'b00; hb[m][j] = 2'b00; end
      k_a[m] = 0; k_b[m] = 0; n_a[m] = 0; n_b[m] = 0; qv[m] = 0; mq[m] = 0;
      mpos[m] = '0; mshoot[m] = 0; mskip[m] = 0;
      acc_a[m] = 0; acc_b[m] = 0; mduty_a[m] = 0; mduty_b[m] = 0;
    end
    nsamp = 0;
    mdv = 0;
  endtask

  task automatic model_edge();
    bit clr, wend;
    int q, d;
    clr  = mon_if.clear;
    wend = 0;
    if (!clr) begin
      nsamp++;
      wend = (nsamp == WIN_LEN);
      if (wend) nsamp = 0;
    end else nsamp = 0;
    mdv = wend;
    for (int m = 0; m < MC; m++) begin
      for (int j = 5; j > 0; j--) begin ha[m][j] = ha[m][j-1]; hb[m][j] = hb[m][j-1]; end
      ha[m][0] = {mon_if.PHASE_A2[m], mon_if.PHASE_A1[m]};
      hb[m][0] = {mon_if.PHASE_B2[m], mon_if.PHASE_B1[m]};
      if (accepted(ha[m][2], ha[m][3], ha[m][4], ha[m][5])) begin k_a[m] = 1; n_a[m] = (ha[m][2] == 2'b10); end
      if (accepted(hb[m][2], hb[m][3], hb[m][4], hb[m][5])) begin k_b[m] = 1; n_b[m] = (hb[m][2] == 2'b10); end
      if (k_a[m] && k_b[m]) begin
        q = qtab[n_a[m]][n_b[m]];
        if (qv[m]) begin
          d = (q - mq[m] + 4) % 4;
          if (d == 1) mpos[m] = mpos[m] + 1;
          else if (d == 3) mpos[m] = mpos[m] - 1;
          else if (d == 2) mskip[m] = 1;
        end
        qv[m] = 1;
        mq[m] = q;
      end
      if (ha[m][2] == 2'b11 || hb[m][2] == 2'b11) mshoot[m] = 1;
      if (clr) begin
        mpos[m] = '0; mshoot[m] = 0; mskip[m] = 0; acc_a[m] = 0; acc_b[m] = 0;
      end else begin
        acc_a[m] += int'(is_drv(ha[m][2]));
        acc_b[m] += int'(is_drv(hb[m][2]));
        if (wend) begin
          mduty_a[m] = acc_a[m]; mduty_b[m] = acc_b[m];
          acc_a[m] = 0; acc_b[m] = 0;
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_edge();
  end

  // ---------------- stimulus helpers ----------------
  int cq [MC];

  task automatic drive(input int m, input int q, input bit a_off, input bit b_off, input bit a_shoot);
    bit an, bn;
    an = (q == 1) || (q == 2);
    bn = (q == 2) || (q == 3);
    cq[m] = q;
    mon_if.PHASE_A1[m] = a_shoot ? 1'b1 : (!a_off && !an);
    mon_if.PHASE_A2[m] = a_shoot ? 1'b1 : (!a_off && an);
    mon_if.PHASE_B1[m] = !b_off && !bn;
    mon_if.PHASE_B2[m] = !b_off && bn;
  endtask

  function automatic longint pos_of(input int m);
    logic signed [SB-1:0] p;
    p = mon_if.position[m*SB +: SB];
    return longint'(p);
  endfunction

  task automatic compare_all();
    for (int m = 0; m < MC; m++) begin
      chk($sformatf("pos%0d", m), pos_of(m), longint'(mpos[m]));
      chk($sformatf("shoot%0d", m), longint'(mon_if.fault_shoot[m]), longint'(mshoot[m]));
      chk($sformatf("skip%0d", m), longint'(mon_if.fault_skip[m]), longint'(mskip[m]));
      chk($sformatf("duty_a%0d", m), longint'(mon_if.duty_a[m*WB +: WB]), longint'(mduty_a[m]));
      chk($sformatf("duty_b%0d", m), longint'(mon_if.duty_b[m*WB +: WB]), longint'(mduty_b[m]));
    end
    chk("duty_valid", longint'(mon_if.duty_valid), longint'(mdv));
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      compare_all();
    end
  endtask

  task automatic pulse_clear();
    mon_if.clear = 1'b1;
    run(1);
    mon_if.clear = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int ndv, r;
    int dwell [MC];
    longint exp_pos;
    model_reset();
    mon_if.PHASE_A1 = '0; mon_if.PHASE_A2 = '0;
    mon_if.PHASE_B1 = '0; mon_if.PHASE_B2 = '0;
    mon_if.clear    = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    compare_all();
    chk("rst_pos", longint'(mon_if.position), 0);
    chk("rst_dv", longint'(mon_if.duty_valid), 0);

    // Forward walk 0->1->2->3->0 with latency checks on each step.
    drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0);
    run(20);
    exp_pos = 0;
    for (int i = 1; i <= 4; i++) begin
      drive(0, i % 4, 0, 0, 0);
      run(LAT - 1);
      chk("lat_hold", pos_of(0), exp_pos);
      run(1);
      exp_pos++;
      chk("lat_step", pos_of(0), exp_pos);
      run(20 - LAT);
    end
    chk("fwd4", pos_of(0), 4);
    chk("fwd_faults", longint'({mon_if.fault_shoot[0], mon_if.fault_skip[0]}), 0);

    // Reverse 0->3->2, then a skip 2->0.
    pulse_clear();
    chk("clr_pos", pos_of(0), 0);
    drive(0, 3, 0, 0, 0); run(20);
    drive(0, 2, 0, 0, 0); run(20);
    chk("rev2", pos_of(0), -2);
    drive(0, 0, 0, 0, 0); run(20);
    chk("skip_flag", longint'(mon_if.fault_skip[0]), 1);
    chk("skip_pos", pos_of(0), -2);

    // Single-cycle shoot-through on coil A, sticky until clear.
    pulse_clear();
    drive(0, 0, 0, 0, 1); run(1);
    drive(0, 0, 0, 0, 0); run(10);
    chk("shoot_set", longint'(mon_if.fault_shoot[0]), 1);
    run(10);
    chk("shoot_sticky", longint'(mon_if.fault_shoot[0]), 1);
    pulse_clear();
    chk("shoot_clr", longint'(mon_if.fault_shoot[0]), 0);
    chk("shoot_clr_pos", pos_of(0), 0);
    drive(0, 1, 0, 0, 0); run(20);
    chk("after_clr_step", pos_of(0), 1);

    // Duty: coil A driven 5 of every 15 cycles, coil B held POS.
    drive(0, 0, 0, 0, 0);
    run(10);
    pulse_clear();
    ndv = 0;
    for (int c = 0; c < 60; c++) begin
      drive(0, 0, (c % 15) >= 5, 0, 0);
      run(1);
      if (c >= 15 && mon_if.duty_valid) ndv++;
    end
    chk("duty_a", longint'(mon_if.duty_a[0 +: WB]), 5);
    chk("duty_b", longint'(mon_if.duty_b[0 +: WB]), 15);
    chk("dv_count", ndv, 3);

    // Two motors stepping in opposite directions at the same time.
    drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0);
    run(10);
    pulse_clear();
    for (int i = 0; i < 3; i++) begin
      drive(1, i + 1, 0, 0, 0);
      if (i < 2) drive(0, 3 - i, 0, 0, 0);
      run(20);
    end
    chk("m1_fwd3", pos_of(1), 3);
    chk("m0_rev2", pos_of(0), -2);

    // Asynchronous reset mid-run clears every output at once.
    rst = 1'b1;
    #1;
    chk("arst_pos", longint'(mon_if.position), 0);
    chk("arst_duty", longint'({mon_if.duty_a, mon_if.duty_b}), 0);
    chk("arst_flags", longint'({mon_if.fault_shoot, mon_if.fault_skip, mon_if.duty_valid}), 0);
    @(negedge clk);
    rst = 1'b0;
    compare_all();

    // Short NEG glitch on coil A, then a stable change.
    drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0);
    run(20);
    drive(0, 1, 0, 0, 0); run(2);
    drive(0, 0, 0, 0, 0); run(20);
    exp_pos = longint'(mpos[0]);
    drive(0, 1, 0, 0, 0);
    run(LAT - 1);
    chk("dg_hold", pos_of(0), exp_pos);
    run(1);
    chk("dg_step", pos_of(0), exp_pos + 1);
    run(10);

    // Random walk with chopping, glitches, skips, shoot-through and clears.
    for (int m = 0; m < MC; m++) dwell[m] = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int m = 0; m < MC; m++) begin
        if (dwell[m] == 0) begin
          r = $urandom_range(0, 9);
          if (r < 4)      cq[m] = (cq[m] + 1) % 4;
          else if (r < 8) cq[m] = (cq[m] + 3) % 4;
          else if (r == 8) cq[m] = (cq[m] + 2) % 4;
          dwell[m] = $urandom_range(1, 12);
        end else dwell[m]--;
        drive(m, cq[m], $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 199) == 0);
      end
      mon_if.clear = ($urandom_range(0, 149) == 0);
      run(1);
    end
    mon_if.clear = 1'b0;
    run(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
